// File: rtl/xbar_frame_ser.sv
// Multi-channel parallel-to-serial framer: start bit, channel 0..PORTS-1 data, optional parity, stop bit.
// Define XBAR_SER_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module xbar_frame_ser #(
    parameter int PORTS        = 4,
    parameter int PACKET_WIDTH = 8,
    parameter int BIT_DIV      = 10,
    parameter int LSB_FIRST    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PORTS*PACKET_WIDTH-1:0] in_data,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int FW = PORTS * PACKET_WIDTH;
    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef XBAR_SER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [BW-1:0]   bidx, bidx_nxt;
    logic [FW-1:0]   shreg, shreg_nxt;
    logic [FW-1:0]   shreg_sh;
    logic            par, par_nxt;
    logic            so_nxt;
    logic            bit_end;
    logic            accept;

    // Reorders the frame so the first bit on the line sits at bit 0 and the register simply shifts right.
    function automatic logic [FW-1:0] send_order(input logic [FW-1:0] d);
        logic [FW-1:0] o;
        o = '0;
        for (int c = 0; c < PORTS; c++) begin
            for (int k = 0; k < PACKET_WIDTH; k++) begin
                if (LSB_FIRST != 0)
                    o[c*PACKET_WIDTH + k] = d[c*PACKET_WIDTH + k];
                else
                    o[c*PACKET_WIDTH + k] = d[c*PACKET_WIDTH + PACKET_WIDTH - 1 - k];
            end
        end
        return o;
    endfunction

    assign bit_end    = (cnt == CNT_LAST);
    assign in_ready   = rst && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_STOP) && bit_end;
    assign shreg_sh   = shreg >> 1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bidx_nxt  = bidx;
        shreg_nxt = shreg;
        par_nxt   = par;
        so_nxt    = serial_out;

        if (state != S_IDLE)
            cnt_nxt = bit_end ? '0 : cnt + CW'(1);

        case (state)
            S_IDLE: begin
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    so_nxt    = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    par_nxt = par ^ shreg[0];
                    if (bidx == BIT_LAST) begin
`ifdef XBAR_SER_PARITY_EN
                        state_nxt = S_PARITY;
                        so_nxt    = par ^ shreg[0];
`else
                        state_nxt = S_STOP;
                        so_nxt    = 1'b1;
`endif
                    end else begin
                        bidx_nxt  = bidx + BW'(1);
                        shreg_nxt = shreg_sh;
                        so_nxt    = shreg_sh[0];
                    end
                end
            end
`ifdef XBAR_SER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    so_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end)
                    state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                so_nxt    = 1'b1;
            end
        endcase

        // An accept in the last stop cycle overrides the return to idle: start bit goes out on this edge.
        if (accept) begin
            state_nxt = S_START;
            cnt_nxt   = '0;
            bidx_nxt  = '0;
            shreg_nxt = send_order(in_data);
            par_nxt   = 1'b0;
            so_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bidx       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bidx       <= bidx_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            serial_out <= so_nxt;
        end
    end

endmodule

// File: tb/tb_xbar_frame_ser.sv
// Bench for xbar_frame_ser: MSB-first instance (BIT_DIV=10) and LSB-first instance (BIT_DIV=1).
module tb_xbar_frame_ser;

`ifdef XBAR_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [15:0] d0, d1;
    logic        r0, r1, so0, so1, b0, b1, fd0, fd1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;     // {ch1, ch0}
        logic [15:0] exp_msb;  // bit 15 is first on the line
        logic [15:0] exp_lsb;
        logic        exp_par;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    xbar_frame_ser #(.PORTS(2), .PACKET_WIDTH(8), .BIT_DIV(10), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .serial_out(so0), .busy(b0), .frame_done(fd0)
    );

    xbar_frame_ser #(.PORTS(2), .PACKET_WIDTH(8), .BIT_DIV(1), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .serial_out(so1), .busy(b1), .frame_done(fd1)
    );

    function automatic logic [3:0] outs(input int sel);
        return (sel == 0) ? {so0, b0, fd0, r0} : {so1, b1, fd1, r1};
    endfunction

    // Line order of the 16 data bits: channel 0 first, bit order per channel chosen by lsb.
    function automatic logic [15:0] model_stream(input logic [15:0] data, input bit lsb);
        logic [15:0] s;
        int pos;
        s = '0;
        pos = 15;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) begin
                s[pos] = lsb ? data[c*8 + k] : data[c*8 + 7 - k];
                pos--;
            end
        end
        return s;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] d);
        if (sel == 0) begin
            v0 = v;
            d0 = d;
        end else begin
            v1 = v;
            d1 = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic trace_result(input string name, input int nbad, input int firstk,
                                input logic a, input logic e);
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL %s: %0d bad cycles, first at cycle %0d actual=%0b required=%0b",
                     name, nbad, firstk, a, e);
        end
    endtask

    task automatic idle_check(input int sel, input string name);
        check(name, {28'd0, outs(sel)}, 32'b1001);
    endtask

    task automatic start_frame(input int sel, input logic [15:0] data, input string name);
        int n;
        n = 0;
        while (outs(sel)[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, ".ready_wait"}, {31'd0, outs(sel)[0]}, 32'd1);
        drive(sel, 1'b1, data);
    endtask

    // Accept happens at the next posedge; every cycle of the frame is then compared with the model.
    task automatic check_frame(input int sel, input logic [15:0] stream, input logic par,
                               input logic keep_valid, input logic [15:0] next_data,
                               input bit noise, input string name);
        int div, len;
        int nb[4];
        int fk[4];
        logic [3:0] act, exp, fa, fe;
        div = (sel == 0) ? 10 : 1;
        len = (16 + 2 + PAR) * div;
        for (int i = 0; i < 4; i++) begin
            nb[i] = 0;
            fk[i] = -1;
        end
        fa = '0;
        fe = '0;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            int bp;
            @(negedge clk);
            bp = k / div;
            if (bp == 0)
                exp[3] = 1'b0;
            else if (bp <= 16)
                exp[3] = stream[16 - bp];
            else if (PAR == 1 && bp == 17)
                exp[3] = par;
            else
                exp[3] = 1'b1;
            exp[2] = 1'b1;
            exp[1] = (k == len - 1);
            exp[0] = (k == len - 1);
            act = outs(sel);
            for (int i = 0; i < 4; i++) begin
                if (act[i] !== exp[i]) begin
                    if (nb[i] == 0) begin
                        fk[i] = k;
                        fa[i] = act[i];
                        fe[i] = exp[i];
                    end
                    nb[i]++;
                end
            end
            if (k == len - 1)
                drive(sel, keep_valid, next_data);
            else if (noise)
                drive(sel, 1'($urandom_range(0, 1)), 16'($urandom));
            else
                drive(sel, 1'b0, next_data);
        end
        trace_result({name, ".serial"}, nb[3], fk[3], fa[3], fe[3]);
        trace_result({name, ".busy"},   nb[2], fk[2], fa[2], fe[2]);
        trace_result({name, ".done"},   nb[1], fk[1], fa[1], fe[1]);
        trace_result({name, ".ready"},  nb[0], fk[0], fa[0], fe[0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int sel;

        vecs[0] = '{16'h3CA5, 16'b1010010100111100, 16'b1010010100111100, 1'b0};
        vecs[1] = '{16'h0007, 16'b0000011100000000, 16'b1110000000000000, 1'b1};
        vecs[2] = '{16'h00FF, 16'b1111111100000000, 16'b1111111100000000, 1'b0};
        vecs[3] = '{16'h8001, 16'b0000000110000000, 16'b1000000000000001, 1'b0};
        vecs[4] = '{16'hC412, 16'b0001001011000100, 16'b0100100000100011, 1'b1};

        rst = 1'b0;
        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        check("reset.dut0", {28'd0, outs(0)}, 32'b1000);
        check("reset.dut1", {28'd0, outs(1)}, 32'b1000);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            idle_check(0, "idle.dut0");
            idle_check(1, "idle.dut1");
        end

        for (int i = 0; i < 5; i++) begin
            start_frame(0, vecs[i].data, "tbl.dut0");
            check_frame(0, vecs[i].exp_msb, vecs[i].exp_par, 1'b0, 16'h0, 1'b0, $sformatf("tbl%0d.msb", i));
            @(negedge clk);
            idle_check(0, "tbl.after0");
            start_frame(1, vecs[i].data, "tbl.dut1");
            check_frame(1, vecs[i].exp_lsb, vecs[i].exp_par, 1'b0, 16'h0, 1'b0, $sformatf("tbl%0d.lsb", i));
            @(negedge clk);
            idle_check(1, "tbl.after1");
        end

        // Back-to-back frames with in_valid held high across the stop bit.
        start_frame(0, vecs[2].data, "b2b.dut0");
        check_frame(0, vecs[2].exp_msb, vecs[2].exp_par, 1'b1, vecs[3].data, 1'b0, "b2b0.a");
        check_frame(0, vecs[3].exp_msb, vecs[3].exp_par, 1'b0, 16'h0, 1'b0, "b2b0.b");
        @(negedge clk);
        idle_check(0, "b2b0.after");
        start_frame(1, vecs[2].data, "b2b.dut1");
        check_frame(1, vecs[2].exp_lsb, vecs[2].exp_par, 1'b1, vecs[3].data, 1'b1, "b2b1.a");
        check_frame(1, vecs[3].exp_lsb, vecs[3].exp_par, 1'b0, 16'h0, 1'b1, "b2b1.b");
        @(negedge clk);
        idle_check(1, "b2b1.after");

        // Reset asserted in the middle of a data bit that is low on the line.
        start_frame(0, vecs[0].data, "midrst");
        @(posedge clk);
        #1 drive(0, 1'b0, 16'h0);
        repeat (58) @(negedge clk);
        check("midrst.before", {28'd0, outs(0)}, 32'b0100);
        #1 rst = 1'b0;
        #1 check("midrst.async", {28'd0, outs(0)}, 32'b1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("midrst.release", {28'd0, outs(0)}, 32'b1001);
        start_frame(0, vecs[4].data, "midrst.new");
        check_frame(0, vecs[4].exp_msb, vecs[4].exp_par, 1'b0, 16'h0, 1'b0, "midrst.frame");
        @(negedge clk);
        idle_check(0, "midrst.after");

        for (int i = 0; i < 10; i++) begin
            sel = i % 2;
            rd = 16'($urandom);
            start_frame(sel, rd, "rand");
            check_frame(sel, model_stream(rd, sel == 1), ^rd, 1'b0, 16'h0, 1'b1,
                        $sformatf("rand%0d", i));
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                idle_check(sel, "rand.gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
